// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding command-to-APB master (IDLE/SETUP/ACCESS) with wait timeout.
// Rev 1.0
`default_nettype none

module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam logic [4:0] C_TIMEOUT = 5'(TIMEOUT);

  state_t      state_q;
  logic        psel_q, penable_q, pwrite_q;
  logic [31:0] paddr_q, pwdata_q;
  logic        rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [31:0] rsp_rdata_q;
  logic [4:0]  wait_cnt_q;
  logic [4:0]  wait_cnt_d;

  assign wait_cnt_d = wait_cnt_q + 5'd1;
  assign cmd_ready  = (state_q == S_IDLE);

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q       <= S_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= 32'd0;
      pwdata_q      <= 32'd0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      wait_cnt_q    <= 5'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            psel_q   <= 1'b1;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= 5'd0;
          state_q    <= S_ACCESS;
        end
        S_ACCESS: begin
          // A ready slave wins even on the edge that would otherwise time out.
          if (pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= pwrite_q ? 32'd0 : prdata;
            state_q       <= S_IDLE;
          end else if (wait_cnt_d == C_TIMEOUT) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= 32'd0;
            wait_cnt_q    <= wait_cnt_d;
            state_q       <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed stimulus with a response scoreboard for apb_master_bridge.
// Rev 1.0
`default_nettype none

module tb_apb_master_bridge;

  localparam int TO = 16;

  logic        pclk = 1'b0;
  logic        prst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'd0;
  logic        pslverr = 1'b0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.TIMEOUT(TO)) dut (
    .pclk(pclk), .prst_n(prst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t        sb[$];
  rsp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rsp_cnt = 0;
  int          last_rsp_cycle = 0;
  int          wait_n = 0;
  int          acc_cnt = 0;
  logic        hang = 1'b0;
  logic        s_err = 1'b0;
  logic [31:0] s_rdata = 32'd0;

  // cyc = number of rising edges so far; the cycle opened by edge k is cycle k+1.
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Slave: ready after wait_n ACCESS cycles unless hung; drives junk outside ACCESS.
  always @(negedge pclk) begin
    if (psel && penable) begin
      pready  = !hang && (acc_cnt == wait_n);
      pslverr = s_err;
      prdata  = s_rdata;
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = 32'hBAD0_BAD0;
    end
  end

  // Response monitor.
  always @(negedge pclk) begin
    if (prst_n && rsp_valid) begin
      rsp_cnt++;
      last_rsp_cycle = cyc + 1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.tmo));
        chk("rsp_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rsp_psel", 32'(psel), 32'd0);
      end
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input rsp_t e, input bit push, output int edge_no);
    int g = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && g < 100) begin
      @(posedge pclk);
      #1;
      g++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL accept_wait: got cmd_ready=0 expected 1 within 100 cycles");
      cmd_valid = 1'b0;
      edge_no = -1;
      return;
    end
    if (push) sb.push_back(e);
    @(posedge pclk);
    #1;
    edge_no   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(posedge pclk);
      #1;
      g++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic access_len(input logic [31:0] a, output int n, output bit stable);
    n = 0;
    stable = 1'b1;
    @(posedge pclk);
    #1;
    while (penable && n < 40) begin
      n++;
      if (paddr !== a) stable = 1'b0;
      @(posedge pclk);
      #1;
    end
  endtask

  initial begin
    int  e1, e2, n, r0;
    bit  st;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    prst_n = 1'b1;
    @(posedge pclk);
    #1;

    // Zero-wait write: 10, 11, 00 and response in cycle E+3.
    send(1'b1, 32'h4, 32'hDEAD_BEEF, '{32'h0, 1'b0, 1'b0}, 1'b1, e1);
    chk("t1_setup_sel_en", 32'({psel, penable}), 32'h2);
    chk("t1_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("t1_pwrite", 32'(pwrite), 32'd1);
    @(posedge pclk);
    #1;
    chk("t1_access_sel_en", 32'({psel, penable}), 32'h3);
    @(posedge pclk);
    #1;
    chk("t1_idle_sel_en", 32'({psel, penable}), 32'h0);
    drain();
    chk("t1_latency", 32'(last_rsp_cycle), 32'(e1 + 3));

    // Read with 3 wait states.
    wait_n  = 3;
    s_rdata = 32'hDEAD_BEEF;
    send(1'b0, 32'h4, 32'h0, '{32'hDEAD_BEEF, 1'b0, 1'b0}, 1'b1, e1);
    access_len(32'h4, n, st);
    chk("t2_access_len", 32'(n), 32'd4);
    chk("t2_paddr_stable", 32'(st), 32'd1);
    drain();
    repeat (3) @(posedge pclk);
    #1;
    chk("t2_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

    // Write with slave error.
    wait_n = 0;
    s_err  = 1'b1;
    send(1'b1, 32'd40, 32'h1234_5678, '{32'h0, 1'b1, 1'b0}, 1'b1, e1);
    drain();
    s_err = 1'b0;

    // Read that never completes.
    hang = 1'b1;
    send(1'b0, 32'h100, 32'h0, '{32'h0, 1'b1, 1'b1}, 1'b1, e1);
    access_len(32'h100, n, st);
    chk("t4_access_len", 32'(n), 32'(TO));
    chk("t4_psel_after", 32'(psel), 32'd0);
    drain();

    // Reset in the middle of ACCESS.
    send(1'b0, 32'h200, 32'h0, '{32'h0, 1'b0, 1'b0}, 1'b0, e1);
    @(posedge pclk);
    #1;
    @(posedge pclk);
    #2;
    chk("t5_pre_penable", 32'(penable), 32'd1);
    r0 = rsp_cnt;
    prst_n = 1'b0;
    #1;
    chk("t5_async_sel_en", 32'({psel, penable}), 32'h0);
    chk("t5_async_paddr", paddr, 32'd0);
    #3;
    prst_n = 1'b1;
    hang = 1'b0;
    @(posedge pclk);
    #1;
    chk("t5_ready_after_rst", 32'(cmd_ready), 32'd1);
    repeat (3) @(posedge pclk);
    #1;
    chk("t5_no_rsp", 32'(rsp_cnt), 32'(r0));
    send(1'b1, 32'h300, 32'h5555_AAAA, '{32'h0, 1'b0, 1'b0}, 1'b1, e1);
    drain();

    // Two commands with cmd_valid held across both.
    r0 = rsp_cnt;
    s_rdata = 32'hCAFE_F00D;
    send(1'b1, 32'h10, 32'hAAAA_5555, '{32'h0, 1'b0, 1'b0}, 1'b1, e1);
    send(1'b0, 32'h14, 32'h0, '{32'hCAFE_F00D, 1'b0, 1'b0}, 1'b1, e2);
    chk("t6_spacing", 32'(e2 - e1), 32'd3);
    drain();
    chk("t6_rsp_count", 32'(rsp_cnt - r0), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameters: TIMEOUT, default 16, number of ACCESS cycles with pready low before the transfer is aborted; sizes a 5-bit wait counter, legal range 1..31.
REQ-002 pclk  input  1  single clock; all state changes on the rising edge.
REQ-003 prst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 cmd_valid  input  1  command request from the local initiator.
REQ-005 cmd_ready  output  1  bridge can accept a command; combinational, high only in IDLE.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  transfer address.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-010 rsp_rdata  output  32  read data; 0 for writes and timeouts.
REQ-011 rsp_err  output  1  slave error or timeout; valid with rsp_valid.
REQ-012 rsp_timeout  output  1  transfer aborted by timeout; valid with rsp_valid.
REQ-013 psel  output  1  APB select.
REQ-014 penable  output  1  APB enable.
REQ-015 pwrite  output  1  APB direction.
REQ-016 paddr  output  32  APB address.
REQ-017 pwdata  output  32  APB write data.
REQ-018 pready  input  1  APB slave ready.
REQ-019 prdata  input  32  APB read data.
REQ-020 pslverr  input  1  APB slave error.

Function
REQ-021 FSM states IDLE, SETUP, ACCESS; all APB outputs are registered.
REQ-022 IDLE: psel=0, penable=0; on an edge with cmd_valid && cmd_ready, latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata, then move to SETUP.
REQ-023 SETUP: psel=1, penable=0; move to ACCESS unconditionally on the next edge.
REQ-024 ACCESS: psel=1, penable=1; wait counter cleared on entry and incremented on each edge with pready=0.
REQ-025 ACCESS completion: on an edge with pready=1, move to IDLE and assert rsp_valid for one cycle.
  - rsp_err = pslverr.
  - rsp_timeout = 0.
  - rsp_rdata = prdata for reads; rsp_rdata = 0 for writes.
REQ-026 ACCESS timeout: on the edge where the counter would reach TIMEOUT with pready=0, move to IDLE and pulse rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-027 pready=1 on the timeout edge takes priority as a normal completion.
REQ-028 Latency: accept edge E; SETUP in cycle E+1; ACCESS in cycle E+2; a zero-wait completion pulses rsp_valid in cycle E+3, where cmd_ready is also high.
REQ-029 Minimum back-to-back spacing is 3 cycles per transfer; psel drops for at least one IDLE cycle between transfers.
REQ-030 paddr, pwrite and pwdata stay stable from SETUP through ACCESS, and hold their last value in IDLE.
REQ-031 cmd_valid while busy is ignored; the initiator holds the command until accepted.
REQ-032 pready, prdata and pslverr are ignored outside ACCESS.
REQ-033 rsp_rdata, rsp_err and rsp_timeout hold their value until the next rsp_valid.

Reset
REQ-034 prst_n low forces the following immediately:
  - state = IDLE;
  - psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout = 0;
  - paddr, pwdata, rsp_rdata = 0;
  - wait counter = 0.
REQ-035 Reset during SETUP or ACCESS aborts the transfer with no rsp_valid; cmd_ready is high in the first cycle after release.

Verification
REQ-036 Write addr 0x04 data 0xDEADBEEF, slave pready=1 immediately -> psel/penable pattern 10,11,00; rsp_valid at E+3, rsp_err=0, rsp_rdata=0.
REQ-037 Read addr 0x04, slave pready after 3 wait cycles, prdata=0xDEADBEEF -> ACCESS held 4 cycles, paddr stable, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-038 Write addr 40, slave pslverr=1 with pready -> rsp_valid with rsp_err=1, rsp_timeout=0.
REQ-039 Read, pready held 0, TIMEOUT=16 -> abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel=0.
REQ-040 prst_n pulsed low mid-ACCESS -> psel/penable drop asynchronously, no rsp_valid, next command completes normally.
REQ-041 cmd_valid held high across two queued commands -> the second command is accepted only in IDLE; exactly two rsp_valid pulses, in order.
